// File: rtl/pair_pkg.sv
// rtl/pair_pkg.sv - shared pair word type, default field width and field-split helper
package pair_pkg;

    localparam int FIELD_W_DEFAULT = 4;

    typedef struct packed {
        logic [FIELD_W_DEFAULT-1:0] b;
        logic [FIELD_W_DEFAULT-1:0] a;
    } pair_t;

    function automatic void pair_unpack(
        input  pair_t                      p,
        output logic [FIELD_W_DEFAULT-1:0] a,
        output logic [FIELD_W_DEFAULT-1:0] b
    );
        a = p.a;
        b = p.b;
    endfunction

endpackage

// File: rtl/pair_fifo_ctrl.sv
// rtl/pair_fifo_ctrl.sv - FIFO pointers, occupancy, push/pop enables and sticky overflow
module pair_fifo_ctrl
    import pair_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic full;
    logic empty;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Full blocks the push even when a pop happens in the same cycle
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Pointers are exactly log2(DEPTH) bits, so wrap comes for free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pair_unpack_fifo.sv
// rtl/pair_unpack_fifo.sv - packed {b,a} word FIFO with unpacked head; PAIR_UNPACK_SUM_EN adds out_sum
module pair_unpack_fifo
    import pair_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEFAULT,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*FIELD_W-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIELD_W-1:0]         out_a,
    output logic [FIELD_W-1:0]         out_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef PAIR_UNPACK_SUM_EN
    output logic [FIELD_W:0]           out_sum,
`endif
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    pair_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .overflow  (overflow)
    );

    // Storage is intentionally not reset; the head is only meaningful with out_valid
    if (FIELD_W == FIELD_W_DEFAULT) begin : g_pair
        pair_t mem [DEPTH];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= pair_t'(in_data);
            end
        end

        always_comb begin
            out_a = '0;
            out_b = '0;
            pair_unpack(mem[rd_ptr], out_a, out_b);
        end
    end else begin : g_wide
        logic [2*FIELD_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end

        always_comb begin
            out_a = mem[rd_ptr][FIELD_W-1:0];
            out_b = mem[rd_ptr][2*FIELD_W-1:FIELD_W];
        end
    end

`ifdef PAIR_UNPACK_SUM_EN
    assign out_sum = {1'b0, out_a} + {1'b0, out_b};
`endif

endmodule

// File: tb/tb_pair_unpack_fifo.sv
// tb/tb_pair_unpack_fifo.sv - randomized and directed self-checking bench for pair_unpack_fifo
module tb_pair_unpack_fifo;

    localparam int FW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2*FW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_a;
    logic [FW-1:0] out_b;
    logic [2:0]    count;
    logic          overflow;
`ifdef PAIR_UNPACK_SUM_EN
    logic [FW:0]   out_sum;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    pair_unpack_fifo #(
        .FIELD_W (FW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
`ifdef PAIR_UNPACK_SUM_EN
        .out_sum   (out_sum),
`endif
        .overflow  (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT state against the queue model
    always @(negedge clk) begin
        check("cmp_in_ready", int'(in_ready), int'(q.size() != DEPTH));
        check("cmp_out_valid", int'(out_valid), int'(q.size() != 0));
        check("cmp_count", int'(count), q.size());
        check("cmp_overflow", int'(overflow), int'(m_ovf));
        if (q.size() != 0) begin
            check("cmp_out_a", int'(out_a), int'(q[0] % 16));
            check("cmp_out_b", int'(out_b), int'(q[0] / 16));
`ifdef PAIR_UNPACK_SUM_EN
            check("cmp_out_sum", int'(out_sum), int'(q[0] % 16) + int'(q[0] / 16));
`endif
        end
    end

    // Advance one clock edge and update the model from the inputs held across it
    task automatic tick();
        bit full_now;
        bit do_push;
        bit do_pop;
        @(posedge clk);
        if (rst_n) begin
            full_now = (q.size() == DEPTH);
            do_push  = in_valid && !full_now;
            do_pop   = out_ready && (q.size() != 0);
            if (in_valid && full_now) m_ovf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
        end
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_list [4];
        exp_list[0] = 8'h01; exp_list[1] = 8'h12; exp_list[2] = 8'h23; exp_list[3] = 8'h34;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: first word latency
        push_word(8'h3A);
        check("t1_out_valid", int'(out_valid), 1);
        check("t1_out_a", int'(out_a), 'hA);
        check("t1_out_b", int'(out_b), 'h3);
        check("t1_count", int'(count), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // 2: fill, overflow, ordered drain
        for (int i = 0; i < 4; i++) push_word(exp_list[i]);
        check("t2_in_ready", int'(in_ready), 0);
        check("t2_count", int'(count), 4);
        push_word(8'h45);
        check("t2_overflow", int'(overflow), 1);
        check("t2_count_full", int'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_pop_a", int'(out_a), int'(exp_list[i] % 16));
            check("t2_pop_b", int'(out_b), int'(exp_list[i] / 16));
            tick();
        end
        out_ready = 1'b0;
        check("t2_empty", int'(out_valid), 0);

        // 3: streaming with pointer wrap
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i);
            tick();
            check("t3_count", int'(count), 1);
            check("t3_head", int'({out_b, out_a}), i);
        end
        in_valid = 1'b0; tick(); out_ready = 1'b0;

        // 4: push+pop at count 2
        push_word(8'h5A);
        push_word(8'h6B);
        in_valid = 1'b1; in_data = 8'hF0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t4_count", int'(count), 2);
        check("t4_head", int'({out_b, out_a}), 'h6B);
        tick();
        check("t4_tail", int'({out_b, out_a}), 'hF0);
        tick(); out_ready = 1'b0;

        // 5: async reset mid-cycle
        push_word(8'h11);
        push_word(8'h22);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_count", int'(count), 0);
        check("t5_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_word(8'hC5);
        check("t5_out_a", int'(out_a), 'h5);
        check("t5_out_b", int'(out_b), 'hC);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef PAIR_UNPACK_SUM_EN
        // 6: zero-extended sum
        push_word(8'hFF);
        check("t6_sum_ff", int'(out_sum), 'h1E);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        push_word(8'h00);
        check("t6_sum_00", int'(out_sum), 'h00);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            in_data   = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        check("end_empty", int'(out_valid), 0);

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
